bcd_updown_timer: RTL and testbench
===================================

BCD_UPDOWN_TIMER -- requirements
Module: bcd_updown_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of BCD decades (1..6).
REQ-002 SHALL have parameter PRESCALE, default 1, clk cycles per count step (>=1).
REQ-003 SHALL have parameter WRAP, default 1, 1 = wrap at terminal, 0 = saturate and stop.
REQ-004 SHALL have parameter BUZZ_CYCLES, default 4, buzzer pulse length in clk cycles (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-high (1 = in reset) despite the name.
REQ-007 SHALL have port up_down  input  1  direction, 1 = up, 0 = down.
REQ-008 SHALL have port start  input  1  level, enter RUNNING.
REQ-009 SHALL have port stop  input  1  level, enter STOPPED.
REQ-010 SHALL have port load  input  1  level, load load_val.
REQ-011 SHALL have port load_val  input  4*DIGITS  BCD preset, digit 0 in [3:0].
REQ-012 SHALL have port bcd  output  4*DIGITS  current value, BCD.
REQ-013 SHALL have port count  output  CW  same value in binary, CW = clog2(10**DIGITS).
REQ-014 SHALL have port running  output  1  high in RUNNING.
REQ-015 SHALL have port tc  output  1  one-cycle terminal-count pulse.
REQ-016 SHALL have port buzzer  output  1  alarm output.

Function
REQ-017 SHALL implement two states, STOPPED and RUNNING; per-cycle priority is load > stop > start.
REQ-018 SHALL, on load, set bcd/count from load_val next edge, clear the prescaler, enter STOPPED; any digit >9 SHALL be clamped to 9.
REQ-019 SHALL treat start and stop asserted together as stop.
REQ-020 SHALL, in RUNNING, step once every PRESCALE cycles; the prescaler is cleared on entering RUNNING, so the first step occurs PRESCALE cycles after start is sampled.
REQ-021 SHALL step +1 (up_down=1) or -1 (up_down=0) with decimal carry/borrow across all digits; up_down is sampled on each step edge.
REQ-022 SHALL keep count equal to the binary value of bcd on every cycle.
REQ-023 SHALL define terminal as all-9s (MAX) when counting up and 0 when counting down.
REQ-024 SHALL, with WRAP=1, step MAX->0 (up) and 0->MAX (down), asserting tc for the cycle in which the wrapped value appears, and stay RUNNING.
REQ-025 SHALL, with WRAP=0, assert tc on the step that reaches the terminal, hold that value, and enter STOPPED; start at the terminal in the same direction SHALL only pulse tc again with no value change.
REQ-026 SHALL drive buzzer high for exactly BUZZ_CYCLES cycles starting the cycle after tc; a new tc during a pulse SHALL restart the full length.
REQ-027 SHALL not cancel a buzzer pulse on load, stop or start; only reset clears it.
REQ-028 SHALL drive running high exactly while in RUNNING.

Reset
REQ-029 SHALL, while rst_n=1, force bcd=0, count=0, running=0, tc=0, buzzer=0, state STOPPED, prescaler and buzzer timer to 0, without waiting for a clock edge.
REQ-030 SHALL resume from STOPPED with value 0 after rst_n deasserts, including a reset applied mid-run or mid-buzz.

Structure
REQ-031 SHALL place the state enum, the BCD digit max constant (9) and the CW width function in shared package bcd_timer_pkg.
REQ-032 SHALL use one sub-module, bcd_digit, a single decade with inc/dec enable, carry/borrow in/out and load, instantiated DIGITS times.

Verification
REQ-033 SHALL cover: with DIGITS=2, PRESCALE=1, WRAP=1, reset then start, up -> bcd 00,01,...,99,00; tc high on the 00 cycle; buzzer high the next 4 cycles.
REQ-034 SHALL cover: load_val=8'h0F -> bcd=09, count=9, running=0.
REQ-035 SHALL cover: load 05, down, start with WRAP=0 -> 04..00, tc once, running drops, bcd holds 00.
REQ-036 SHALL cover: start and stop both high while RUNNING at 37 -> STOPPED, bcd stays 37; load together with start -> loaded value, STOPPED.
REQ-037 SHALL cover: PRESCALE=3 -> one step every 3 cycles, first step 3 cycles after start.
REQ-038 SHALL cover: rst_n pulse mid-buzzer at value 42 -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared state type, BCD digit limit and binary width helper for the BCD timer.
package bcd_timer_pkg;
    typedef enum logic {STOPPED, RUNNING} state_t;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    function automatic int cw(input int digits);
        int p = 1;
        for (int i = 0; i < digits; i++) p *= 10;
        return $clog2(p);
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade with up/down step, ripple carry/borrow and clamped load.
//   clk, rst (async, active-high), load/load_val (preset, >9 clamps to 9),
//   inc/dec (step direction enables), cin (step this decade), cout (ripple to next), digit (value).
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    input  logic       dec,
    input  logic       cin,
    output logic       cout,
    output logic [3:0] digit
);
    assign cout = cin & (inc ? (digit == DIGIT_MAX) : (dec & (digit == 4'd0)));
    always_ff @(posedge clk or posedge rst)
        if (rst)
            digit <= 4'd0;
        else if (load)
            digit <= (load_val > DIGIT_MAX) ? DIGIT_MAX : load_val;
        else if (cin & inc)
            digit <= (digit == DIGIT_MAX) ? 4'd0 : digit + 4'd1;
        else if (cin & dec)
            digit <= (digit == 4'd0) ? DIGIT_MAX : digit - 4'd1;
endmodule

// File: rtl/bcd_updown_timer.sv
// bcd_updown_timer: prescaled BCD up/down timer with wrap or saturate, terminal pulse and buzzer.
//   clk, rst_n (async reset, active-HIGH despite the name), up_down (1 = up), start/stop/load (levels,
//   priority load > stop > start), load_val (BCD preset), bcd/count (value in BCD and binary),
//   running (RUNNING state), tc (one-cycle terminal pulse), buzzer (BUZZ_CYCLES pulse after tc).
module bcd_updown_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int PRESCALE = 1,
    parameter int WRAP = 1,
    parameter int BUZZ_CYCLES = 4,
    localparam int CW = cw(DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                up_down,
    input  logic                start,
    input  logic                stop,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] bcd,
    output logic [CW-1:0]       count,
    output logic                running,
    output logic                tc,
    output logic                buzzer
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = $clog2(BUZZ_CYCLES + 1);
    localparam logic [CW-1:0] MAX = CW'(10 ** DIGITS - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic [BW-1:0] bcnt;
    logic [DIGITS:0] cy;
    logic          last, term, near, step, inc, dec;

    assign last = (state == RUNNING) && (presc == PW'(PRESCALE - 1));
    assign term = up_down ? (count == MAX) : (count == '0);
    // one step away from terminal: saturating mode stops on the step that lands there
    assign near = up_down ? (count == MAX - CW'(1)) : (count == CW'(1));
    // saturating mode never steps off the terminal; the step edge only re-pulses tc
    assign step = last & ~load & ~stop & ((WRAP != 0) | ~term);
    assign inc = step & up_down;
    assign dec = step & ~up_down;
    assign cy[0] = 1'b1;
    assign running = (state == RUNNING);
    assign buzzer = (bcnt != '0);

    always_comb begin
        count = '0;
        for (int i = DIGITS - 1; i >= 0; i--) count = count * CW'(10) + CW'(bcd[4*i +: 4]);
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk(clk), .rst(rst_n), .load(load), .load_val(load_val[4*i +: 4]),
            .inc(inc), .dec(dec), .cin(cy[i]), .cout(cy[i+1]), .digit(bcd[4*i +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            state <= STOPPED;
            presc <= '0;
            tc <= 1'b0;
            bcnt <= '0;
        end else begin
            // a fresh tc reloads the full pulse; load/stop/start never touch it
            bcnt <= tc ? BW'(BUZZ_CYCLES) : bcnt - BW'(bcnt != '0);
            tc <= 1'b0;
            if (load || stop) begin
                state <= STOPPED;
                presc <= '0;
            end else if (state == STOPPED) begin
                state <= start ? RUNNING : STOPPED;
                presc <= '0;
            end else begin
                presc <= last ? '0 : presc + PW'(1);
                if (last) begin
                    // in wrap mode the carry out of the top decade marks the wrap
                    tc <= (WRAP != 0) ? cy[DIGITS] : (term | near);
                    if (WRAP == 0 && (term || near)) state <= STOPPED;
                end
            end
        end
endmodule

// File: tb/tb_bcd_updown_timer.sv
// tb_bcd_updown_timer: scoreboard bench for bcd_updown_timer (wrap, saturate and prescaled builds).
module tb_bcd_updown_timer;
    typedef struct {
        int   v;
        logic t;
        logic r;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, up_down = 1'b1, start = 1'b0, stop = 1'b0, load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] a_bcd, w_bcd, p_bcd;
    logic [6:0] a_cnt, w_cnt, p_cnt;
    logic       a_run, a_tc, a_buz, w_run, w_tc, w_buz, p_run, p_tc, p_buz;
    int         checks = 0, passed = 0;
    exp_t       q[$];

    always #5 clk = ~clk;

    bcd_updown_timer #(.DIGITS(2), .PRESCALE(1), .WRAP(1), .BUZZ_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .up_down(up_down), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .bcd(a_bcd), .count(a_cnt), .running(a_run), .tc(a_tc), .buzzer(a_buz));
    bcd_updown_timer #(.DIGITS(2), .PRESCALE(1), .WRAP(0), .BUZZ_CYCLES(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .up_down(up_down), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .bcd(w_bcd), .count(w_cnt), .running(w_run), .tc(w_tc), .buzzer(w_buz));
    bcd_updown_timer #(.DIGITS(2), .PRESCALE(3), .WRAP(1), .BUZZ_CYCLES(4)) dut_p (
        .clk(clk), .rst_n(rst_n), .up_down(up_down), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .bcd(p_bcd), .count(p_cnt), .running(p_run), .tc(p_tc), .buzzer(p_buz));

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if ({a_bcd, a_cnt, a_run, a_tc, a_buz} !== 18'd0) $display("FAIL reset_a got=%h exp=0", {a_bcd, a_cnt, a_run, a_tc, a_buz}); else passed++;
        checks++; if ({w_bcd, w_run, p_bcd, p_run} !== 18'd0) $display("FAIL reset_wp got=%h exp=0", {w_bcd, w_run, p_bcd, p_run}); else passed++;
        rst_n = 1'b0;
        tick();
        checks++; if ({a_bcd, a_run} !== 9'd0) $display("FAIL reset_release got=%h exp=0", {a_bcd, a_run}); else passed++;
    endtask

    task automatic test_count_up();
        exp_t e;
        up_down = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (a_run !== 1'b1 || a_bcd !== 8'h00) $display("FAIL up_start run=%b bcd=%h exp run=1 bcd=00", a_run, a_bcd); else passed++;
        for (int v = 1; v <= 100; v++) q.push_back('{v % 100, v == 100, 1'b1});
        while (q.size() != 0) begin
            tick();
            e = q.pop_front();
            checks++;
            if (a_bcd !== to_bcd(e.v) || a_cnt !== 7'(e.v) || a_tc !== e.t || a_run !== e.r)
                $display("FAIL up_step bcd=%h cnt=%0d tc=%b run=%b exp bcd=%h cnt=%0d tc=%b run=%b", a_bcd, a_cnt, a_tc, a_run, to_bcd(e.v), e.v, e.t, e.r);
            else passed++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (a_buz !== (i < 4) || a_tc !== 1'b0) $display("FAIL up_buzzer cycle=%0d buz=%b tc=%b exp buz=%b tc=0", i, a_buz, a_tc, i < 4); else passed++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (a_run !== 1'b0 || a_bcd !== 8'h05) $display("FAIL up_stop run=%b bcd=%h exp run=0 bcd=05", a_run, a_bcd); else passed++;
    endtask

    task automatic test_load_clamp();
        load = 1'b1;
        load_val = 8'h0F;
        tick();
        checks++; if (a_bcd !== 8'h09 || a_cnt !== 7'd9 || a_run !== 1'b0) $display("FAIL clamp_0f bcd=%h cnt=%0d run=%b exp bcd=09 cnt=9 run=0", a_bcd, a_cnt, a_run); else passed++;
        load_val = 8'hF3;
        tick();
        load = 1'b0;
        checks++; if (a_bcd !== 8'h93 || a_cnt !== 7'd93) $display("FAIL clamp_f3 bcd=%h cnt=%0d exp bcd=93 cnt=93", a_bcd, a_cnt); else passed++;
    endtask

    task automatic test_wrap0_down();
        exp_t e;
        up_down = 1'b0;
        load = 1'b1;
        load_val = 8'h05;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (w_run !== 1'b1 || w_bcd !== 8'h05) $display("FAIL sat_start run=%b bcd=%h exp run=1 bcd=05", w_run, w_bcd); else passed++;
        for (int v = 4; v >= 0; v--) q.push_back('{v, v == 0, v != 0});
        for (int i = 0; i < 2; i++) q.push_back('{0, 1'b0, 1'b0});
        while (q.size() != 0) begin
            tick();
            e = q.pop_front();
            checks++;
            if (w_bcd !== to_bcd(e.v) || w_cnt !== 7'(e.v) || w_tc !== e.t || w_run !== e.r)
                $display("FAIL sat_step bcd=%h cnt=%0d tc=%b run=%b exp bcd=%h cnt=%0d tc=%b run=%b", w_bcd, w_cnt, w_tc, w_run, to_bcd(e.v), e.v, e.t, e.r);
            else passed++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (w_run !== 1'b1 || w_bcd !== 8'h00 || w_tc !== 1'b0) $display("FAIL sat_restart run=%b bcd=%h tc=%b exp run=1 bcd=00 tc=0", w_run, w_bcd, w_tc); else passed++;
        tick();
        checks++; if (w_run !== 1'b0 || w_bcd !== 8'h00 || w_tc !== 1'b1) $display("FAIL sat_repulse run=%b bcd=%h tc=%b exp run=0 bcd=00 tc=1", w_run, w_bcd, w_tc); else passed++;
    endtask

    task automatic test_start_stop();
        up_down = 1'b1;
        load = 1'b1;
        load_val = 8'h35;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++; if (a_run !== 1'b1 || a_bcd !== 8'h37) $display("FAIL ss_run run=%b bcd=%h exp run=1 bcd=37", a_run, a_bcd); else passed++;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        checks++; if (a_run !== 1'b0 || a_bcd !== 8'h37) $display("FAIL ss_both run=%b bcd=%h exp run=0 bcd=37", a_run, a_bcd); else passed++;
        tick();
        checks++; if (a_run !== 1'b0 || a_bcd !== 8'h37) $display("FAIL ss_hold run=%b bcd=%h exp run=0 bcd=37", a_run, a_bcd); else passed++;
        load = 1'b1;
        start = 1'b1;
        load_val = 8'h12;
        tick();
        load = 1'b0;
        start = 1'b0;
        checks++; if (a_run !== 1'b0 || a_bcd !== 8'h12 || a_cnt !== 7'd12) $display("FAIL ss_load run=%b bcd=%h cnt=%0d exp run=0 bcd=12 cnt=12", a_run, a_bcd, a_cnt); else passed++;
    endtask

    task automatic test_prescale();
        exp_t e;
        up_down = 1'b1;
        load = 1'b1;
        load_val = 8'h00;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (p_run !== 1'b1 || p_bcd !== 8'h00) $display("FAIL pre_start run=%b bcd=%h exp run=1 bcd=00", p_run, p_bcd); else passed++;
        for (int i = 1; i <= 9; i++) q.push_back('{i / 3, 1'b0, 1'b1});
        while (q.size() != 0) begin
            tick();
            e = q.pop_front();
            checks++;
            if (p_bcd !== to_bcd(e.v) || p_cnt !== 7'(e.v) || p_run !== e.r)
                $display("FAIL pre_step bcd=%h cnt=%0d run=%b exp bcd=%h cnt=%0d run=%b", p_bcd, p_cnt, p_run, to_bcd(e.v), e.v, e.r);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_buzz();
        up_down = 1'b1;
        load = 1'b1;
        load_val = 8'h99;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (a_tc !== 1'b1 || a_bcd !== 8'h00) $display("FAIL rb_wrap tc=%b bcd=%h exp tc=1 bcd=00", a_tc, a_bcd); else passed++;
        tick();
        load = 1'b1;
        load_val = 8'h42;
        tick();
        load = 1'b0;
        checks++; if (a_buz !== 1'b1 || a_bcd !== 8'h42 || a_run !== 1'b0) $display("FAIL rb_load buz=%b bcd=%h run=%b exp buz=1 bcd=42 run=0", a_buz, a_bcd, a_run); else passed++;
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if ({a_bcd, a_cnt, a_run, a_tc, a_buz} !== 18'd0) $display("FAIL rb_async got=%h exp=0", {a_bcd, a_cnt, a_run, a_tc, a_buz}); else passed++;
        tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (a_run !== 1'b1 || a_bcd !== 8'h00 || a_buz !== 1'b0) $display("FAIL rb_resume run=%b bcd=%h buz=%b exp run=1 bcd=00 buz=0", a_run, a_bcd, a_buz); else passed++;
        tick();
        checks++; if (a_bcd !== 8'h01 || a_cnt !== 7'd1) $display("FAIL rb_step bcd=%h cnt=%0d exp bcd=01 cnt=1", a_bcd, a_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_clamp();
        test_wrap0_down();
        test_start_stop();
        test_prescale();
        test_reset_mid_buzz();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
